// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse-code digit keyer:
//   - state_e            : keyer FSM states
//   - MORSE_LEN          : symbols per digit
//   - *_UNITS            : element lengths in Morse time units
//   - digit_to_pattern() : BCD digit -> 5-symbol pattern (1 = dash, MSB first);
//                          also used by the combinational display path.
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int MORSE_LEN = 5;

    localparam logic [1:0] DOT_UNITS   = 2'd1;
    localparam logic [1:0] DASH_UNITS  = 2'd3;
    localparam logic [1:0] SPACE_UNITS = 2'd1;
    localparam logic [1:0] GAP_UNITS   = 2'd3;

    // Digits above 9 map to all-dots; callers are expected to reject them.
    function automatic logic [MORSE_LEN-1:0] digit_to_pattern(input logic [3:0] d);
        logic [MORSE_LEN-1:0] p;
        case (d)
            4'd0:    p = 5'b11111;
            4'd1:    p = 5'b01111;
            4'd2:    p = 5'b00111;
            4'd3:    p = 5'b00011;
            4'd4:    p = 5'b00001;
            4'd5:    p = 5'b00000;
            4'd6:    p = 5'b10000;
            4'd7:    p = 5'b11000;
            4'd8:    p = 5'b11100;
            4'd9:    p = 5'b11110;
            default: p = 5'b00000;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// -----------------------------------------------------------------------------
// morse_unit_timer
// Loadable down-counter measuring Morse elements in whole units.
//   clk       in  board clock
//   reset_n   in  asynchronous active-low reset
//   load_i    in  reload the counter for units_i units
//   units_i   in  element length in units (1..3)
//   expire_o  out high in the last cycle of the loaded interval
// Loading N units makes expire_o assert on the N*UNIT_CYCLES-th cycle after
// the load edge, so a state entered with a load lasts exactly N units.
// -----------------------------------------------------------------------------
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_i,
    input  logic [1:0] units_i,
    output logic       expire_o
);

    localparam int TW = $clog2(3 * UNIT_CYCLES);

    localparam logic [TW-1:0] LOAD_1U = TW'(UNIT_CYCLES - 1);
    localparam logic [TW-1:0] LOAD_2U = TW'(2 * UNIT_CYCLES - 1);
    localparam logic [TW-1:0] LOAD_3U = TW'(3 * UNIT_CYCLES - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            case (units_i)
                2'd1:    cnt_d = LOAD_1U;
                2'd2:    cnt_d = LOAD_2U;
                2'd3:    cnt_d = LOAD_3U;
                default: cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            // Parks at zero once expired so an idle timer draws no activity.
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/morse_keyer_ctrl.sv
// -----------------------------------------------------------------------------
// morse_keyer_ctrl
// Plays a BCD digit as a 5-symbol Morse pattern on a single key output and
// presents the latched parallel pattern.
//   clk       in  board clock
//   reset_n   in  asynchronous active-low reset
//   digit     in  [3:0] digit to send, sampled on an accepted start
//   start     in  request strobe, accepted only while idle
//   repeat_i  in  (MORSE_REPEAT_EN only) replay the pattern after the gap
//   busy      out high while transmitting
//   done      out one-cycle pulse at end of transmission or on rejection
//   key_out   out Morse key, 1 = mark
//   pattern   out [4:0] latched pattern, MSB sent first, 1 = dash
//   invalid   out latched digit was > 9
// Optional feature macro: MORSE_REPEAT_EN.
// -----------------------------------------------------------------------------
module morse_keyer_ctrl
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
`ifdef MORSE_REPEAT_EN
    input  logic                 repeat_i,
`endif
    input  logic [3:0]           digit,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 key_out,
    output logic [MORSE_LEN-1:0] pattern,
    output logic                 invalid
);

    state_e               state_q, state_d;
    logic [2:0]           sym_idx_q, sym_idx_d;
    logic [MORSE_LEN-1:0] pattern_q, pattern_d;
    logic                 invalid_q, invalid_d;
    logic                 done_q, done_d;
    logic                 key_q, key_d;
    logic                 busy_q, busy_d;

    logic                 tmr_load;
    logic [1:0]           tmr_units;
    logic                 tmr_expire;
    logic [2:0]           sym_dec;

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (tmr_load),
        .units_i  (tmr_units),
        .expire_o (tmr_expire)
    );

    assign sym_dec = sym_idx_q - 3'd1;

    always_comb begin
        state_d   = state_q;
        sym_idx_d = sym_idx_q;
        pattern_d = pattern_q;
        invalid_d = invalid_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_units = DOT_UNITS;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (digit <= 4'd9) begin
                        pattern_d = digit_to_pattern(digit);
                        sym_idx_d = 3'd4;
                        invalid_d = 1'b0;
                        state_d   = MARK;
                        tmr_load  = 1'b1;
                        tmr_units = pattern_d[4] ? DASH_UNITS : DOT_UNITS;
                    end else begin
                        invalid_d = 1'b1;
                        pattern_d = '0;
                        done_d    = 1'b1;
                    end
                end
            end
            MARK: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (sym_idx_q == 3'd0) begin
                        state_d   = GAP;
                        tmr_units = GAP_UNITS;
                    end else begin
                        state_d   = SPACE;
                        tmr_units = SPACE_UNITS;
                    end
                end
            end
            SPACE: begin
                if (tmr_expire) begin
                    sym_idx_d = sym_dec;
                    state_d   = MARK;
                    tmr_load  = 1'b1;
                    tmr_units = pattern_q[sym_dec] ? DASH_UNITS : DOT_UNITS;
                end
            end
            GAP: begin
                if (tmr_expire) begin
`ifdef MORSE_REPEAT_EN
                    if (repeat_i) begin
                        // Replay back-to-back: busy stays high, no done pulse.
                        sym_idx_d = 3'd4;
                        state_d   = MARK;
                        tmr_load  = 1'b1;
                        tmr_units = pattern_q[4] ? DASH_UNITS : DOT_UNITS;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        key_d  = (state_d == MARK);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sym_idx_q <= '0;
            pattern_q <= '0;
            invalid_q <= 1'b0;
            done_q    <= 1'b0;
            key_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_idx_q <= sym_idx_d;
            pattern_q <= pattern_d;
            invalid_q <= invalid_d;
            done_q    <= done_d;
            key_q     <= key_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign key_out = key_q;
    assign pattern = pattern_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_morse_keyer_ctrl
// Directed bench for morse_keyer_ctrl with UNIT_CYCLES = 4 (dot 4, dash 12,
// space 4, gap 12 cycles). Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_morse_keyer_ctrl;

    localparam int U = 4;

    logic       clk;
    logic       reset_n;
    logic [3:0] digit;
    logic       start;
    logic       busy;
    logic       done;
    logic       key_out;
    logic [4:0] pattern;
    logic       invalid;
`ifdef MORSE_REPEAT_EN
    logic       repeat_i;
`endif

    int total;
    int bad;

    logic exp_key [0:399];

    morse_keyer_ctrl #(
        .UNIT_CYCLES (U)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
`ifdef MORSE_REPEAT_EN
        .repeat_i (repeat_i),
`endif
        .digit    (digit),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .key_out  (key_out),
        .pattern  (pattern),
        .invalid  (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Expected key waveform: per symbol a mark (dot 1U / dash 3U) then a
    // 1U space, except the last symbol which is followed by the 3U gap.
    task automatic build_exp(input logic [4:0] pat, input int reps);
        int idx;
        idx = 0;
        for (int k = 0; k < 400; k++) exp_key[k] = 1'b0;
        for (int r = 0; r < reps; r++) begin
            for (int b = 4; b >= 0; b--) begin
                for (int k = 0; k < (pat[b] ? 3 * U : U); k++) begin
                    exp_key[idx] = 1'b1;
                    idx++;
                end
                idx = idx + ((b == 0) ? 3 * U : U);
            end
        end
    endtask

    // Called at a falling edge; raises start so it is taken at the next
    // rising edge, then samples busy_len+1 cycles, ending at the done cycle.
    task automatic play(input string tag, input logic [3:0] d, input logic [4:0] pat,
                        input int busy_len, input int reps, input int inj, input int drop);
        int mism, bcnt, dcnt, dpos;
        build_exp(pat, reps);
        mism = 0; bcnt = 0; dcnt = 0; dpos = -1;
        digit = d;
        start = 1'b1;
        for (int i = 0; i <= busy_len; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (inj >= 0 && i == inj) begin
                digit = 4'd3;
                start = 1'b1;
            end
            if (inj >= 0 && i == inj + 1) start = 1'b0;
`ifdef MORSE_REPEAT_EN
            if (drop >= 0 && i == drop) repeat_i = 1'b0;
`else
            if (drop >= 0 && i == drop) digit = 4'd0;
`endif
            if (key_out !== exp_key[i]) mism++;
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                dcnt++;
                dpos = i;
            end
        end
        check({tag, "_key_wave_mismatches"}, mism, 0);
        check({tag, "_busy_cycles"}, bcnt, busy_len);
        check({tag, "_done_count"}, dcnt, 1);
        check({tag, "_done_pos"}, dpos, busy_len);
        check({tag, "_pattern"}, pattern, pat);
        check({tag, "_invalid"}, invalid, 1'b0);
    endtask

    initial begin
        int dcnt, bcnt;
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        digit   = 4'd0;
        start   = 1'b0;
`ifdef MORSE_REPEAT_EN
        repeat_i = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_key", key_out, 1'b0);
        check("rst_pattern", pattern, 5'b00000);
        check("rst_invalid", invalid, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Digit 1 .---- : 80 busy cycles
        play("d1", 4'd1, 5'b01111, 80, 1, -1, -1);
        // Start in the done cycle is accepted: digit 5 ..... : 48 cycles
        play("d5", 4'd5, 5'b00000, 48, 1, -1, -1);

        // Digit 12 rejected, again from the done cycle
        digit = 4'd12;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("inv_invalid", invalid, 1'b1);
        check("inv_done", done, 1'b1);
        check("inv_busy", busy, 1'b0);
        check("inv_key", key_out, 1'b0);
        check("inv_pattern", pattern, 5'b00000);
        @(negedge clk);
        check("inv_done_cleared", done, 1'b0);
        check("inv_invalid_hold", invalid, 1'b1);
        check("inv_busy_hold", busy, 1'b0);

        // Digit 0 ----- clears invalid: 88 cycles
        play("d0", 4'd0, 5'b11111, 88, 1, -1, -1);

        // Digit 7 --... with a digit-3 start pulsed mid-transmission: 64 cycles
        play("d7inj", 4'd7, 5'b11000, 64, 1, 10, -1);

        // Reset in the middle of the first dash of digit 0
        digit = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_key_before", key_out, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_key", key_out, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        dcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
            if (busy === 1'b1) bcnt++;
        end
        check("mid_rst_no_done", dcnt, 0);
        check("mid_rst_idle_busy", bcnt, 0);
        play("d5_after_rst", 4'd5, 5'b00000, 48, 1, -1, -1);

`ifdef MORSE_REPEAT_EN
        // Digit 9 ----. repeated once, repeat dropped during the second pass
        repeat_i = 1'b1;
        play("d9rep", 4'd9, 5'b11110, 160, 2, -1, 100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
